// File: rtl/activation_serializer.sv
// activation_serializer: captures a vector of activations and streams it one element per beat, tracking argmax
module activation_serializer #(
    parameter int          N           = 16,
    parameter logic [11:0] EngineCount = 12'd4095
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                start_i,
    input  logic [11:0]         count_i,
    input  logic signed [N-1:0] value_i [EngineCount],
    input  logic                ready_i,
    output logic                valid_o,
    output logic signed [N-1:0] value_o,
    output logic [11:0]         index_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [11:0]         argmax_o,
    output logic signed [N-1:0] max_o
);
    localparam int AW = (EngineCount > 12'd1) ? $clog2(EngineCount) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t              state;
    logic signed [N-1:0] buf_q [EngineCount];
    logic [11:0]         cnt_q;
    logic [11:0]         cnt_lat;
    logic [11:0]         nxt;
    logic                capture;

    // Clamp requested length to the lane count and form the next lane index
    always_comb begin
        cnt_lat = (count_i > EngineCount) ? EngineCount : count_i;
        nxt     = index_o + 12'd1;
        capture = en_i && state == IDLE && start_i;
    end

    // Snapshot all lanes at capture so later value_i changes cannot leak into the stream
    always_ff @(posedge clk_i) begin
        if (capture) buf_q <= value_i;
    end

    // Control FSM with registered beat, completion and running-max outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt_q    <= '0;
            valid_o  <= 1'b0;
            value_o  <= '0;
            index_o  <= '0;
            last_o   <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            argmax_o <= '0;
            max_o    <= '0;
        end else if (en_i) begin
            case (state)
                IDLE: if (start_i) begin
                    cnt_q    <= cnt_lat;
                    index_o  <= '0;
                    argmax_o <= '0;
                    max_o    <= '0;
                    busy_o   <= 1'b1;
                    if (cnt_lat != 12'd0) begin
                        state   <= STREAM;
                        valid_o <= 1'b1;
                        value_o <= value_i[0];
                        last_o  <= cnt_lat == 12'd1;
                    end else begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                STREAM: if (ready_i) begin
                    if (index_o == 12'd0 || value_o > max_o) begin
                        max_o    <= value_o;
                        argmax_o <= index_o;
                    end
                    if (last_o) begin
                        state   <= DONE;
                        valid_o <= 1'b0;
                        last_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else begin
                        index_o <= nxt;
                        value_o <= buf_q[nxt[AW-1:0]];
                        last_o  <= nxt == cnt_q - 12'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_activation_serializer.sv
// tb_activation_serializer: directed checks of streaming, backpressure, clamping, argmax, reset and enable
module tb_activation_serializer;
    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               en_i;
    logic               start_i;
    logic [11:0]        count_i;
    logic signed [15:0] value_i [4];
    logic               ready_i;
    logic               valid_o;
    logic signed [15:0] value_o;
    logic [11:0]        index_o;
    logic               last_o;
    logic               busy_o;
    logic               done_o;
    logic [11:0]        argmax_o;
    logic signed [15:0] max_o;

    int checks = 0;
    int errors = 0;

    activation_serializer #(.N(16), .EngineCount(12'd4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .start_i(start_i),
        .count_i(count_i), .value_i(value_i), .ready_i(ready_i),
        .valid_o(valid_o), .value_o(value_o), .index_o(index_o), .last_o(last_o),
        .busy_o(busy_o), .done_o(done_o), .argmax_o(argmax_o), .max_o(max_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input string tag, input int v, input int i, input logic l);
        chk({tag, " valid"}, 32'(valid_o), 32'd1);
        chk({tag, " value"}, 32'(value_o), 32'(v));
        chk({tag, " index"}, 32'(index_o), 32'(i));
        chk({tag, " last"},  32'(last_o),  32'(l));
    endtask

    task automatic finish_chk(input string tag, input int am, input int mx);
        chk({tag, " done"},   32'(done_o),   32'd1);
        chk({tag, " dvalid"}, 32'(valid_o),  32'd0);
        chk({tag, " dlast"},  32'(last_o),   32'd0);
        chk({tag, " argmax"}, 32'(argmax_o), 32'(am));
        chk({tag, " max"},    32'(max_o),    32'(mx));
        step();
        chk({tag, " done1"},  32'(done_o),   32'd0);
        chk({tag, " idle"},   32'(busy_o),   32'd0);
    endtask

    task automatic launch(input int cnt);
        count_i = 12'(cnt);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        en_i    = 1'b1;
        start_i = 1'b0;
        count_i = '0;
        ready_i = 1'b1;
        value_i = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        #3;
        chk("rst valid",  32'(valid_o),  32'd0);
        chk("rst busy",   32'(busy_o),   32'd0);
        chk("rst done",   32'(done_o),   32'd0);
        chk("rst value",  32'(value_o),  32'd0);
        chk("rst index",  32'(index_o),  32'd0);
        chk("rst max",    32'(max_o),    32'd0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        // basic stream with a tie for the maximum
        value_i = '{16'sd5, -16'sd3, 16'sd9, 16'sd9};
        launch(4);
        beat("t1 b0", 5, 0, 1'b0);
        chk("t1 busy", 32'(busy_o), 32'd1);
        step(); beat("t1 b1", -3, 1, 1'b0);
        step(); beat("t1 b2", 9, 2, 1'b0);
        step(); beat("t1 b3", 9, 3, 1'b1);
        step(); finish_chk("t1", 2, 9);

        // backpressure on beat 1
        launch(4);
        beat("t2 b0", 5, 0, 1'b0);
        step(); beat("t2 b1", -3, 1, 1'b0);
        ready_i = 1'b0;
        step(); beat("t2 hold0", -3, 1, 1'b0);
        step(); beat("t2 hold1", -3, 1, 1'b0);
        step(); beat("t2 hold2", -3, 1, 1'b0);
        ready_i = 1'b1;
        step(); beat("t2 b2", 9, 2, 1'b0);
        step(); beat("t2 b3", 9, 3, 1'b1);
        step(); finish_chk("t2", 2, 9);

        // zero-length request
        launch(0);
        chk("t3 busy", 32'(busy_o), 32'd1);
        finish_chk("t3", 0, 0);

        // oversize request clamps to the lane count
        launch(7);
        beat("t4 b0", 5, 0, 1'b0);
        step(); beat("t4 b1", -3, 1, 1'b0);
        step(); beat("t4 b2", 9, 2, 1'b0);
        step(); beat("t4 b3", 9, 3, 1'b1);
        step(); finish_chk("t4", 2, 9);

        // all negative, tie at the extremes keeps lowest index
        value_i = '{-16'sd1, -16'sd2, -16'sd5, -16'sd1};
        launch(4);
        beat("t5 b0", -1, 0, 1'b0);
        step(); beat("t5 b1", -2, 1, 1'b0);
        step(); beat("t5 b2", -5, 2, 1'b0);
        step(); beat("t5 b3", -1, 3, 1'b1);
        step(); finish_chk("t5", 0, -1);

        // asynchronous reset mid-stream
        value_i = '{16'sd5, -16'sd3, 16'sd9, 16'sd9};
        launch(4);
        step();
        step(); beat("t6 b2", 9, 2, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6 valid",  32'(valid_o),  32'd0);
        chk("t6 value",  32'(value_o),  32'd0);
        chk("t6 index",  32'(index_o),  32'd0);
        chk("t6 busy",   32'(busy_o),   32'd0);
        chk("t6 argmax", 32'(argmax_o), 32'd0);
        chk("t6 max",    32'(max_o),    32'd0);
        step();
        chk("t6 nodone", 32'(done_o),   32'd0);
        rst_ni = 1'b1;
        step();
        chk("t6 idle", 32'(busy_o), 32'd0);
        launch(2);
        beat("t6 r0", 5, 0, 1'b0);
        step(); beat("t6 r1", -3, 1, 1'b1);
        step(); finish_chk("t6", 0, 5);

        // enable stall with a stray start and changed inputs
        launch(4);
        beat("t7 b0", 5, 0, 1'b0);
        step(); beat("t7 b1", -3, 1, 1'b0);
        en_i    = 1'b0;
        start_i = 1'b1;
        value_i = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
        step(); beat("t7 frz0", -3, 1, 1'b0);
        step(); beat("t7 frz1", -3, 1, 1'b0);
        chk("t7 frz max", 32'(max_o), 32'd5);
        en_i = 1'b1;
        step(); beat("t7 b2", 9, 2, 1'b0);
        start_i = 1'b0;
        step(); beat("t7 b3", 9, 3, 1'b1);
        step(); finish_chk("t7", 2, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
